// File: rtl/ram_arb_pkg.sv
// Shared constants and encodings for the RAM3840 two-port arbiter.
package ram_arb_pkg;
   localparam int unsigned DEPTH = 3840;
   localparam int unsigned AW    = 12;
   localparam int unsigned DW    = 16;

   typedef enum logic {
      ST_CLEAR,
      ST_SERVE
   } state_e;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_A,
      SEL_B
   } sel_e;

   function automatic logic in_range(input logic [AW-1:0] addr);
      return 32'(addr) < DEPTH;
   endfunction
endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset zero-fill address sweep: one address per cycle, 0..DEPTH-1.
// done_o flags the cycle that writes the last address; busy_o drops after it.
module ram_clear_seq
   import ram_arb_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_n_i,
   output logic [AW-1:0] addr_o,
   output logic          busy_o,
   output logic          done_o
);
   logic [AW-1:0] addr_q, addr_d;
   logic          busy_q;

   assign done_o = busy_q && (addr_q == AW'(DEPTH - 1));
   assign addr_d = done_o ? '0 : addr_q + AW'(1);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         addr_q <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         addr_q <= addr_d;
         if (done_o) busy_q <= 1'b0;
      end
   end

   assign addr_o = addr_q;
   assign busy_o = busy_q;
endmodule

// File: rtl/ram3840_arbiter.sv
// RAM3840 arbiter: A has priority, B forced after MAX_WAIT denials; read data one cycle after grant,
// no internal buffering (requesters hold until gnt). Define RAM_ARB_CLEAR_EN for the post-reset zero-fill.
module ram3840_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          a_req_i,
   input  logic          a_we_i,
   input  logic [AW-1:0] a_addr_i,
   input  logic [DW-1:0] a_wdata_i,
   output logic          a_gnt_o,
   output logic          a_rvalid_o,
   output logic [DW-1:0] a_rdata_o,
   input  logic          b_req_i,
   input  logic          b_we_i,
   input  logic [AW-1:0] b_addr_i,
   input  logic [DW-1:0] b_wdata_i,
   output logic          b_gnt_o,
   output logic          b_rvalid_o,
   output logic [DW-1:0] b_rdata_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_in_o,
   output logic          mem_load_o,
   input  logic [DW-1:0] mem_out_i,
   output logic          busy_o,
   output logic          oob_o
);
   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);
`ifdef RAM_ARB_CLEAR_EN
   localparam state_e RST_STATE = ST_CLEAR;
`else
   localparam state_e RST_STATE = ST_SERVE;
`endif

   state_e        state_q;
   logic [3:0]    wait_q, wait_d;
   logic          a_rvalid_q, b_rvalid_q, oob_q;
   logic [DW-1:0] a_rdata_q, b_rdata_q;

   sel_e          sel;
   logic          serve;
   logic          win_we, win_in_rng;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_wdata, xfer_rdata;
   logic          clr_busy, clr_done;
   logic [AW-1:0] clr_addr;

`ifdef RAM_ARB_CLEAR_EN
   ram_clear_seq u_clear (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .addr_o  (clr_addr),
      .busy_o  (clr_busy),
      .done_o  (clr_done)
   );
`else
   assign clr_addr = '0;
   assign clr_busy = 1'b0;
   assign clr_done = 1'b0;
`endif

   // Reset is folded in combinationally so nothing is granted while rst_n is low.
   assign serve = rst_n_i && (state_q == ST_SERVE);

   always_comb begin
      sel = SEL_NONE;
      if (serve) begin
         if (b_req_i && (wait_q == MAX_W)) sel = SEL_B;
         else if (a_req_i)                 sel = SEL_A;
         else if (b_req_i)                 sel = SEL_B;
      end
   end

   always_comb begin
      win_we    = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      case (sel)
         SEL_A: begin
            win_we    = a_we_i;
            win_addr  = a_addr_i;
            win_wdata = a_wdata_i;
         end
         SEL_B: begin
            win_we    = b_we_i;
            win_addr  = b_addr_i;
            win_wdata = b_wdata_i;
         end
         default: ;
      endcase
   end

   assign win_in_rng = in_range(win_addr);
   assign xfer_rdata = !win_in_rng ? '0 : (win_we ? win_wdata : mem_out_i);

   always_comb begin
      mem_addr_o = '0;
      mem_in_o   = '0;
      mem_load_o = 1'b0;
      if (sel != SEL_NONE) begin
         mem_addr_o = win_addr;
         mem_in_o   = win_wdata;
         mem_load_o = win_we && win_in_rng;
      end else if (clr_busy && rst_n_i) begin
         mem_addr_o = clr_addr;
         mem_load_o = 1'b1;
      end
   end

   always_comb begin
      wait_d = '0;
      if (b_req_i && (sel != SEL_B))
         wait_d = (wait_q == MAX_W) ? wait_q : wait_q + 4'd1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= RST_STATE;
         wait_q     <= '0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
         oob_q      <= 1'b0;
      end else begin
         wait_q     <= wait_d;
         a_rvalid_q <= (sel == SEL_A);
         b_rvalid_q <= (sel == SEL_B);
         oob_q      <= (sel != SEL_NONE) && !win_in_rng;
         if (sel == SEL_A) a_rdata_q <= xfer_rdata;
         if (sel == SEL_B) b_rdata_q <= xfer_rdata;
         case (state_q)
            ST_CLEAR: if (clr_done) state_q <= ST_SERVE;
            default:  ;
         endcase
      end
   end

   assign a_gnt_o    = (sel == SEL_A);
   assign b_gnt_o    = (sel == SEL_B);
   assign a_rvalid_o = a_rvalid_q;
   assign b_rvalid_o = b_rvalid_q;
   assign a_rdata_o  = a_rdata_q;
   assign b_rdata_o  = b_rdata_q;
   assign oob_o      = oob_q;
   assign busy_o     = clr_busy;
endmodule

// File: tb/tb_ram3840_arbiter.sv
// Directed bench for ram3840_arbiter with a behavioural RAM3840 model.
module tb_ram3840_arbiter;
   logic        clk;
   logic        rst_n;
   logic        a_req, a_we, b_req, b_we;
   logic [11:0] a_addr, b_addr;
   logic [15:0] a_wdata, b_wdata;
   logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [15:0] a_rdata, b_rdata;
   logic [11:0] mem_addr;
   logic [15:0] mem_in, mem_out;
   logic        mem_load, busy, oob;

   int tests = 0;
   int errs  = 0;

   logic [15:0] ram [0:3839];

   ram3840_arbiter #(.MAX_WAIT(4)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .a_req_i    (a_req),
      .a_we_i     (a_we),
      .a_addr_i   (a_addr),
      .a_wdata_i  (a_wdata),
      .a_gnt_o    (a_gnt),
      .a_rvalid_o (a_rvalid),
      .a_rdata_o  (a_rdata),
      .b_req_i    (b_req),
      .b_we_i     (b_we),
      .b_addr_i   (b_addr),
      .b_wdata_i  (b_wdata),
      .b_gnt_o    (b_gnt),
      .b_rvalid_o (b_rvalid),
      .b_rdata_o  (b_rdata),
      .mem_addr_o (mem_addr),
      .mem_in_o   (mem_in),
      .mem_load_o (mem_load),
      .mem_out_i  (mem_out),
      .busy_o     (busy),
      .oob_o      (oob)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM3840: async read, sync write; out-of-range reads return junk
   always_comb begin
      mem_out = 16'hDEAD;
      if (mem_addr < 12'd3840) mem_out = ram[mem_addr];
   end
   always @(posedge clk) if (mem_load && mem_addr < 12'd3840) ram[mem_addr] <= mem_in;

   initial begin
      #3_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct packed {
      logic ar; logic aw; logic [11:0] aa; logic [15:0] awd;
      logic br; logic bw; logic [11:0] ba; logic [15:0] bwd;
      logic eag; logic ebg; logic eload; logic [11:0] emaddr; logic [15:0] emin;
      logic earv; logic [15:0] eard; logic ebrv; logic [15:0] ebrd; logic eoob;
   } vec_t;

   vec_t vt [14];

   task automatic idle_inputs();
      a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
   endtask

`ifdef RAM_ARB_CLEAR_EN
   // Follows one sweep from the current negedge; optionally aborts at stop_addr.
   task automatic sweep(input string nm, input int stop_addr);
      int cnt;
      int bad;
      cnt = 0;
      bad = 0;
      a_req = 1; a_addr = 12'd5;
      while (busy && cnt < 5000) begin
         if (stop_addr >= 0 && cnt == stop_addr) break;
         if (mem_addr != 12'(cnt) || !mem_load || a_gnt || mem_in != 16'h0) bad++;
         cnt++;
         @(negedge clk);
      end
      a_req = 0; a_addr = 0;
      chk({nm, "_cycles"}, 32'(cnt), (stop_addr >= 0) ? 32'(stop_addr) : 32'd3840);
      chk({nm, "_order"}, 32'(bad), 32'd0);
   endtask

   task automatic rd_a(input logic [11:0] addr, input logic [15:0] exp);
      a_req = 1; a_we = 0; a_addr = addr;
      #1;
      chk($sformatf("clr_rd%0d_gnt", addr), 32'(a_gnt), 32'd1);
      @(negedge clk);
      a_req = 0; a_addr = 0;
      chk($sformatf("clr_rd%0d_rvalid", addr), 32'(a_rvalid), 32'd1);
      chk($sformatf("clr_rd%0d_rdata", addr), 32'(a_rdata), 32'(exp));
   endtask
`endif

   initial begin
`ifdef RAM_ARB_CLEAR_EN
      for (int i = 0; i < 3840; i++) ram[i] = 16'hDEAD;
`else
      for (int i = 0; i < 3840; i++) ram[i] = 16'h0000;
`endif
      vt[0]  = '{0,0,12'd0,16'h0,       0,0,12'd0,16'h0,       0,0,0,12'd0,16'h0,       0,16'h0,    0,16'h0,    0};
      vt[1]  = '{1,1,12'd100,16'h1234,  0,0,12'd0,16'h0,       1,0,1,12'd100,16'h1234,  1,16'h1234, 0,16'h0,    0};
      vt[2]  = '{1,0,12'd100,16'h0,     0,0,12'd0,16'h0,       1,0,0,12'd100,16'h0,     1,16'h1234, 0,16'h0,    0};
      vt[3]  = '{0,0,12'd0,16'h0,       0,0,12'd0,16'h0,       0,0,0,12'd0,16'h0,       0,16'h1234, 0,16'h0,    0};
      vt[4]  = '{1,1,12'd7,16'hAAAA,    1,1,12'd7,16'h5555,    1,0,1,12'd7,16'hAAAA,    1,16'hAAAA, 0,16'h0,    0};
      vt[5]  = '{0,0,12'd0,16'h0,       1,1,12'd7,16'h5555,    0,1,1,12'd7,16'h5555,    0,16'hAAAA, 1,16'h5555, 0};
      vt[6]  = '{1,0,12'd7,16'h0,       0,0,12'd0,16'h0,       1,0,0,12'd7,16'h0,       1,16'h5555, 0,16'h5555, 0};
      vt[7]  = '{0,0,12'd0,16'h0,       1,1,12'd3839,16'hBEEF, 0,1,1,12'd3839,16'hBEEF, 0,16'h5555, 1,16'hBEEF, 0};
      vt[8]  = '{0,0,12'd0,16'h0,       1,1,12'd3840,16'hFFFF, 0,1,0,12'd3840,16'hFFFF, 0,16'h5555, 1,16'h0,    1};
      vt[9]  = '{0,0,12'd0,16'h0,       1,0,12'd3839,16'h0,    0,1,0,12'd3839,16'h0,    0,16'h5555, 1,16'hBEEF, 0};
      vt[10] = '{1,0,12'd4095,16'h0,    0,0,12'd0,16'h0,       1,0,0,12'd4095,16'h0,    1,16'h0,    0,16'hBEEF, 1};
      vt[11] = '{1,1,12'd4000,16'h1111, 1,0,12'd3839,16'h0,    1,0,0,12'd4000,16'h1111, 1,16'h0,    0,16'hBEEF, 1};
      vt[12] = '{0,0,12'd0,16'h0,       1,0,12'd3839,16'h0,    0,1,0,12'd3839,16'h0,    0,16'h0,    1,16'hBEEF, 0};
      vt[13] = '{1,0,12'd3839,16'h0,    0,0,12'd0,16'h0,       1,0,0,12'd3839,16'h0,    1,16'hBEEF, 0,16'hBEEF, 0};

      // Reset with both requesters active: nothing may be granted or written
      idle_inputs();
      rst_n = 0; a_req = 1; b_req = 1; a_we = 1; a_addr = 12'd9; a_wdata = 16'h7777;
      repeat (3) @(negedge clk);
      chk("rst_agnt", 32'(a_gnt), 32'd0);
      chk("rst_bgnt", 32'(b_gnt), 32'd0);
      chk("rst_load", 32'(mem_load), 32'd0);
      chk("rst_arvalid", 32'(a_rvalid), 32'd0);
      chk("rst_brvalid", 32'(b_rvalid), 32'd0);
      chk("rst_ardata", 32'(a_rdata), 32'd0);
      chk("rst_brdata", 32'(b_rdata), 32'd0);
      chk("rst_oob", 32'(oob), 32'd0);
`ifdef RAM_ARB_CLEAR_EN
      chk("rst_busy", 32'(busy), 32'd1);
`else
      chk("rst_busy", 32'(busy), 32'd0);
`endif
      idle_inputs();
      rst_n = 1;

`ifdef RAM_ARB_CLEAR_EN
      sweep("clr0", 2000);
      chk("clr0_at2000", 32'(mem_addr), 32'd2000);
      rst_n = 0;
      repeat (2) @(negedge clk);
      chk("clr_rst_busy", 32'(busy), 32'd1);
      chk("clr_rst_load", 32'(mem_load), 32'd0);
      rst_n = 1;
      #1;
      chk("clr_restart_addr", 32'(mem_addr), 32'd0);
      sweep("clr1", -1);
      chk("clr_busy_done", 32'(busy), 32'd0);
      rd_a(12'd0, 16'h0);
      rd_a(12'd1919, 16'h0);
      rd_a(12'd3839, 16'h0);
`endif

      foreach (vt[i]) begin
         a_req = vt[i].ar; a_we = vt[i].aw; a_addr = vt[i].aa; a_wdata = vt[i].awd;
         b_req = vt[i].br; b_we = vt[i].bw; b_addr = vt[i].ba; b_wdata = vt[i].bwd;
         #1;
         chk($sformatf("v%0d_agnt", i), 32'(a_gnt), 32'(vt[i].eag));
         chk($sformatf("v%0d_bgnt", i), 32'(b_gnt), 32'(vt[i].ebg));
         chk($sformatf("v%0d_load", i), 32'(mem_load), 32'(vt[i].eload));
         chk($sformatf("v%0d_maddr", i), 32'(mem_addr), 32'(vt[i].emaddr));
         chk($sformatf("v%0d_min", i), 32'(mem_in), 32'(vt[i].emin));
         @(negedge clk);
         chk($sformatf("v%0d_arvalid", i), 32'(a_rvalid), 32'(vt[i].earv));
         chk($sformatf("v%0d_ardata", i), 32'(a_rdata), 32'(vt[i].eard));
         chk($sformatf("v%0d_brvalid", i), 32'(b_rvalid), 32'(vt[i].ebrv));
         chk($sformatf("v%0d_brdata", i), 32'(b_rdata), 32'(vt[i].ebrd));
         chk($sformatf("v%0d_oob", i), 32'(oob), 32'(vt[i].eoob));
      end

      // Continuous contention: B must win exactly every fifth cycle
      idle_inputs();
      a_req = 1; a_addr = 12'd5; b_req = 1; b_addr = 12'd6;
      for (int i = 0; i < 22; i++) begin
         #1;
         if (i < 20) begin
            chk($sformatf("starve%0d_agnt", i), 32'(a_gnt), (i % 5 == 4) ? 32'd0 : 32'd1);
            chk($sformatf("starve%0d_bgnt", i), 32'(b_gnt), (i % 5 == 4) ? 32'd1 : 32'd0);
         end
         @(negedge clk);
      end
      // Dropping b_req clears the wait count: B then waits the full bound again
      b_req = 0;
      #1;
      chk("cancel_bgnt", 32'(b_gnt), 32'd0);
      @(negedge clk);
      b_req = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("rewait%0d_bgnt", i), 32'(b_gnt), (i == 4) ? 32'd1 : 32'd0);
         @(negedge clk);
      end

      // Reset mid-traffic with a partly accumulated wait count
      repeat (3) @(negedge clk);
      rst_n = 0;
      #1;
      chk("rst2_agnt", 32'(a_gnt), 32'd0);
      chk("rst2_bgnt", 32'(b_gnt), 32'd0);
      @(negedge clk);
      chk("rst2_arvalid", 32'(a_rvalid), 32'd0);
      chk("rst2_ardata", 32'(a_rdata), 32'd0);
      chk("rst2_brdata", 32'(b_rdata), 32'd0);
`ifndef RAM_ARB_CLEAR_EN
      rst_n = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("postrst%0d_bgnt", i), 32'(b_gnt), (i == 4) ? 32'd1 : 32'd0);
         @(negedge clk);
      end
`else
      chk("rst2_busy", 32'(busy), 32'd1);
`endif
      idle_inputs();
      rst_n = 1;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end
endmodule
